// File: rtl/microwave_ctrl.sv
// Microwave control FSM: keypad digit loading, start/pause/resume/clear of the countdown timer, magnetron gating, done/beep.
// Latency: all outputs registered, one cycle after the sampled input. Backpressure: none, inputs are sampled every cycle.
// Optional beeper counter enabled by defining MICROWAVE_BEEP_EN; otherwise beep is tied low.
module microwave_ctrl #(
    parameter int MAX_DIGITS  = 3,
    parameter int BEEP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] timer_data,
    output logic       timer_loadn,
    output logic       timer_clrn,
    output logic       timer_en,
    output logic       mag_on,
    output logic       done,
    output logic       beep,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_COOKING = 3'd2,
        S_PAUSED  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int                CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_DIGITS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   digit_cnt, cnt_d;
    logic [3:0]         data_d;
    logic               load, clr;
    logic               key_ok;

    assign key_ok = key_valid && (key_digit <= 4'd9) && (digit_cnt < MAX_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = digit_cnt;
        data_d  = timer_data;
        load    = 1'b0;
        clr     = 1'b0;
        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (stop) begin
                    clr     = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (key_ok) begin
                    data_d  = key_digit;
                    load    = 1'b1;
                    cnt_d   = digit_cnt + 1'b1;
                    state_d = S_ENTRY;
                end else if (state_q == S_ENTRY && start && door_closed && !timer_zero) begin
                    // A digit load takes priority so timer_en never overlaps a load strobe.
                    state_d = S_COOKING;
                end
            end
            S_COOKING: begin
                if (timer_zero)
                    state_d = S_DONE;
                else if (!door_closed || stop)
                    state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (stop) begin
                    clr     = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (start && door_closed) begin
                    state_d = S_COOKING;
                end
            end
            S_DONE: begin
                if (key_valid || start || stop || !door_closed) begin
                    clr     = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                clr     = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            digit_cnt   <= '0;
            timer_data  <= 4'd0;
            timer_loadn <= 1'b1;
            timer_clrn  <= 1'b0;
            timer_en    <= 1'b0;
            mag_on      <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt   <= cnt_d;
            timer_data  <= data_d;
            timer_loadn <= ~load;
            timer_clrn  <= ~clr;
            timer_en    <= (state_d == S_COOKING);
            mag_on      <= (state_d == S_COOKING);
            done        <= (state_d == S_DONE);
        end
    end

    assign state = state_q;

`ifdef MICROWAVE_BEEP_EN
    localparam logic [7:0] BEEP_LOAD = 8'(BEEP_CYCLES - 1);
    logic [7:0] beep_cnt;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            beep     <= 1'b0;
            beep_cnt <= 8'd0;
        end else if (state_d == S_DONE && state_q != S_DONE) begin
            beep     <= 1'b1;
            beep_cnt <= BEEP_LOAD;
        end else if (state_d != S_DONE || beep_cnt == 8'd0) begin
            beep     <= 1'b0;
        end else begin
            beep_cnt <= beep_cnt - 8'd1;
        end
    end
`else
    // BEEP_CYCLES is at least 1, so this is constant 0.
    assign beep = (BEEP_CYCLES == 0);
`endif

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed self-checking bench for microwave_ctrl.
module tb_microwave_ctrl;

`ifdef MICROWAVE_BEEP_EN
    localparam int EXP_BEEP = 8;
`else
    localparam int EXP_BEEP = 0;
`endif

    logic       clk = 1'b0;
    logic       clrn, key_valid, start, stop, door_closed, timer_zero;
    logic [3:0] key_digit;
    logic [3:0] timer_data;
    logic       timer_loadn, timer_clrn, timer_en, mag_on, done, beep;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int beep_total;

    microwave_ctrl #(.MAX_DIGITS(3), .BEEP_CYCLES(8)) dut (
        .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
        .timer_data(timer_data), .timer_loadn(timer_loadn), .timer_clrn(timer_clrn),
        .timer_en(timer_en), .mag_on(mag_on), .done(done), .beep(beep), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        clrn = 1'b0; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop = 1'b0;
        door_closed = 1'b1; timer_zero = 1'b1;
        tick(); tick();
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_loadn", 8'(timer_loadn), 8'd1);
        chk("rst_clrn", 8'(timer_clrn), 8'd0);
        chk("rst_en", 8'(timer_en), 8'd0);
        chk("rst_mag", 8'(mag_on), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_beep", 8'(beep), 8'd0);
        chk("rst_data", 8'(timer_data), 8'd0);
        clrn = 1'b1;
        tick();
        chk("post_rst_clrn", 8'(timer_clrn), 8'd1);

        // Plan 1: keys 1,3,0 loaded, 4th ignored
        key(4'd1);
        timer_zero = 1'b0;
        chk("k1_loadn", 8'(timer_loadn), 8'd0);
        chk("k1_data", 8'(timer_data), 8'd1);
        chk("k1_state", 8'(state), 8'd1);
        tick();
        chk("k1_strobe_end", 8'(timer_loadn), 8'd1);
        key(4'd3);
        chk("k3_loadn", 8'(timer_loadn), 8'd0);
        chk("k3_data", 8'(timer_data), 8'd3);
        key(4'd0);
        chk("k0_loadn", 8'(timer_loadn), 8'd0);
        chk("k0_data", 8'(timer_data), 8'd0);
        key(4'd5);
        chk("k4th_loadn", 8'(timer_loadn), 8'd1);
        chk("k4th_data", 8'(timer_data), 8'd0);
        chk("k4th_state", 8'(state), 8'd1);

        // Plan 2: cook, finish, beep
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cook_state", 8'(state), 8'd2);
        chk("cook_en", 8'(timer_en), 8'd1);
        chk("cook_mag", 8'(mag_on), 8'd1);
        tick(); tick();
        chk("cook_hold", 8'(state), 8'd2);
        timer_zero = 1'b1;
        tick();
        chk("done_state", 8'(state), 8'd4);
        chk("done_flag", 8'(done), 8'd1);
        chk("done_en", 8'(timer_en), 8'd0);
        chk("done_mag", 8'(mag_on), 8'd0);
        chk("done_beep0", 8'(beep), (EXP_BEEP > 0) ? 8'd1 : 8'd0);
        beep_total = int'(beep);
        for (int i = 0; i < 12; i++) begin
            tick();
            beep_total += int'(beep);
        end
        chk("beep_cycles", 8'(beep_total), 8'(EXP_BEEP));
        chk("done_stay", 8'(done), 8'd1);
        key(4'd7);
        chk("wake_state", 8'(state), 8'd0);
        chk("wake_clrn", 8'(timer_clrn), 8'd0);
        chk("wake_done", 8'(done), 8'd0);
        chk("wake_beep", 8'(beep), 8'd0);
        chk("wake_key_dropped", 8'(timer_loadn), 8'd1);
        tick();
        chk("wake_clrn_end", 8'(timer_clrn), 8'd1);

        // Plan 3: door opens mid-cook, resume without clear
        key(4'd2);
        timer_zero = 1'b0;
        chk("p3_entry", 8'(state), 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("p3_cook", 8'(state), 8'd2);
        door_closed = 1'b0;
        tick();
        chk("door_mag", 8'(mag_on), 8'd0);
        chk("door_en", 8'(timer_en), 8'd0);
        chk("door_state", 8'(state), 8'd3);
        tick();
        chk("door_still_paused", 8'(state), 8'd3);
        door_closed = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("resume_state", 8'(state), 8'd2);
        chk("resume_mag", 8'(mag_on), 8'd1);
        chk("resume_no_clr", 8'(timer_clrn), 8'd1);

        // Plan 4: stop pauses, second stop clears
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop1_state", 8'(state), 8'd3);
        chk("stop1_en", 8'(timer_en), 8'd0);
        tick();
        chk("stop1_hold", 8'(state), 8'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop2_state", 8'(state), 8'd0);
        chk("stop2_clrn", 8'(timer_clrn), 8'd0);
        tick();
        chk("stop2_clrn_end", 8'(timer_clrn), 8'd1);
        // digit_cnt back to 0: three fresh digits accepted, fourth dropped
        key(4'd4); chk("cnt_k1", 8'(timer_loadn), 8'd0);
        key(4'd5); chk("cnt_k2", 8'(timer_loadn), 8'd0);
        key(4'd6); chk("cnt_k3", 8'(timer_loadn), 8'd0);
        chk("cnt_k3_data", 8'(timer_data), 8'd6);
        key(4'd7); chk("cnt_k4", 8'(timer_loadn), 8'd1);
        // stop beats a same-cycle key in ENTRY
        stop = 1'b1;
        key(4'd8);
        stop = 1'b0;
        chk("stopkey_state", 8'(state), 8'd0);
        chk("stopkey_clrn", 8'(timer_clrn), 8'd0);
        chk("stopkey_loadn", 8'(timer_loadn), 8'd1);
        tick();

        // Plan 5: zero time cannot start; invalid digit ignored
        timer_zero = 1'b1;
        key(4'd0);
        chk("z_loadn", 8'(timer_loadn), 8'd0);
        chk("z_state", 8'(state), 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("z_start_state", 8'(state), 8'd1);
        chk("z_start_mag", 8'(mag_on), 8'd0);
        key(4'd12);
        chk("k12_loadn", 8'(timer_loadn), 8'd1);
        chk("k12_data", 8'(timer_data), 8'd0);
        key(4'd9);
        chk("k9_loadn", 8'(timer_loadn), 8'd0);
        chk("k9_data", 8'(timer_data), 8'd9);

        // Plan 6: reset mid-cook
        timer_zero = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("p6_cook", 8'(state), 8'd2);
        clrn = 1'b0;
        tick();
        chk("mrst_state", 8'(state), 8'd0);
        chk("mrst_en", 8'(timer_en), 8'd0);
        chk("mrst_mag", 8'(mag_on), 8'd0);
        chk("mrst_clrn", 8'(timer_clrn), 8'd0);
        chk("mrst_loadn", 8'(timer_loadn), 8'd1);
        chk("mrst_data", 8'(timer_data), 8'd0);
        tick();
        chk("mrst_clrn_held", 8'(timer_clrn), 8'd0);
        clrn = 1'b1;
        tick();
        chk("mrst_release", 8'(timer_clrn), 8'd1);
        chk("mrst_idle", 8'(state), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl.md
Name: microwave_ctrl

Overview:
Control FSM that sequences the microwave countdown timer (mins / sec_tens / sec_ones counter chain).
- Accepts keypad digits and shifts each into the timer through its parallel-load interface.
- Starts, pauses, resumes and clears the countdown; gates the magnetron.
- Flags completion and drives the done beeper.
- Sits between the keypad/door front end and the timer; same clock domain as the timer.

Parameters:
MAX_DIGITS, 3, max keypad digits accepted per entry (min:sec:sec); further digits ignored.
BEEP_CYCLES, 8, cycles beep is held high on entering DONE (range 1..255).

Ports:
clk  in  1  system clock, rising edge.
clrn  in  1  synchronous active-low reset.
key_valid  in  1  one-cycle strobe: key_digit is valid.
key_digit  in  4  BCD digit 0..9; values 10..15 ignored.
start  in  1  start/resume request, level sampled each cycle.
stop  in  1  pause/cancel request, level sampled each cycle.
door_closed  in  1  1 = door closed.
timer_zero  in  1  timer "all digits zero" flag.
timer_data  out  4  digit presented to the timer load input.
timer_loadn  out  1  active-low load/shift strobe to the timer.
timer_clrn  out  1  active-low clear to the timer.
timer_en  out  1  countdown enable to the timer.
mag_on  out  1  magnetron enable.
done  out  1  cook-complete indicator.
beep  out  1  beeper drive.
state  out  3  current state code, for debug/display.

Behaviour:
- All outputs are registered and change one cycle after the cycle in which the triggering input is sampled.
- Reset (clrn=0 at a clock edge), valid from any state including mid-cook:
  - state=IDLE, digit_cnt=0, timer_data=0.
  - timer_loadn=1, timer_clrn=0 for the reset cycle(s), then 1.
  - timer_en=0, mag_on=0, done=0, beep=0.
- States and codes: IDLE=0, ENTRY=1, COOKING=2, PAUSED=3, DONE=4.
- Digit entry (IDLE or ENTRY), when key_valid=1 and key_digit<=9 and digit_cnt<MAX_DIGITS:
  - timer_data<=key_digit; timer_loadn=0 for exactly one cycle; digit_cnt++; state->ENTRY.
  - Invalid digits and digits beyond MAX_DIGITS: no load strobe, no count change.
  - key_valid is ignored in COOKING and PAUSED.
- IDLE or ENTRY with stop=1:
  - One-cycle timer_clrn=0 pulse; digit_cnt=0; state->IDLE.
  - stop wins over a same-cycle key_valid; the key is discarded.
- ENTRY->COOKING requires start=1 and door_closed=1 and timer_zero=0.
  - Start is ignored if the door is open or the entered time is all zero.
  - On entry to COOKING: timer_en=1, mag_on=1.
- COOKING, priority highest first:
  - timer_zero=1 -> DONE; timer_en=0, mag_on=0, done=1.
  - door_closed=0 -> PAUSED.
  - stop=1 -> PAUSED.
  - In PAUSED: timer_en=0, mag_on=0; the timer holds its value.
- PAUSED, priority highest first:
  - stop=1 -> IDLE with one-cycle timer_clrn=0 pulse and digit_cnt=0.
  - start=1 and door_closed=1 -> COOKING.
- DONE:
  - done=1 while in DONE; beep=1 for BEEP_CYCLES cycles from entry, then 0.
  - Any of key_valid, start, stop, or door_closed=0 -> IDLE; done=0, beep=0, digit_cnt=0, one-cycle timer_clrn=0 pulse.
  - The waking key is discarded.
- timer_loadn and timer_clrn are never low in the same cycle; timer_en is never 1 while either is low.
- mag_on=1 implies door_closed was 1 in the previous cycle. Door opening forces mag_on=0 within one cycle.
- Unused state codes recover to IDLE with a timer clear.

Optional Feature:
MICROWAVE_BEEP_EN.
- Defined: beep behaves as specified above, with an 8-bit down-counter sized for BEEP_CYCLES.
- Undefined: beep is tied to 0, the beep counter is not instantiated, and DONE otherwise behaves identically.

Test Plan:
1. Reset, then keys 1, 3, 0 each with key_valid for one cycle -> three single-cycle timer_loadn=0 pulses with timer_data 1, 3, 0; state=ENTRY; a 4th key 5 produces no strobe.
2. After entry, start=1 with door_closed=1, timer_zero=0 -> next cycle state=COOKING, timer_en=1, mag_on=1. Later timer_zero=1 -> state=DONE, done=1, beep=1 for exactly 8 cycles.
3. COOKING, door_closed drops to 0 -> next cycle mag_on=0, timer_en=0, state=PAUSED. Door closed and start=1 -> COOKING resumes; no timer_clrn pulse occurs.
4. COOKING, stop=1 -> PAUSED; second stop=1 -> IDLE, one timer_clrn=0 pulse, digit_cnt=0.
5. Entry of digit 0 only, start=1 with timer_zero=1 -> state stays ENTRY, mag_on=0. Key 12 -> ignored.
6. clrn=0 during COOKING -> next edge all outputs at reset values, state=IDLE, timer_clrn=0 while reset is held.
